// File: rtl/sort_array_ctrl.sv
// sort_array_ctrl: sequencer for a linear array of DEPTH sorting cells
// (descending key order, cell 0 holds the largest key).
// Phases: load a record stream, let pushes ripple, drain sorted records, clear.
// Key is in_data[19:0]; a zero key looks like an empty cell and is dropped.
// Optional build macro SORT_CTRL_STATS_EN adds o_drop_cnt, a saturating count
// of dropped zero-key records (cleared by rst only).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | array empty, waiting for the first record of a batch
// S_LOAD   | at least one record pushed, accepting more
// S_SETTLE | pushing zero records for DEPTH cycles so in-flight pushes settle
// S_DRAIN  | streaming cells 0..count-1 out over valid/ready
// S_CLEAR  | one-cycle array clear pulse, counters reset, back to idle
module sort_array_ctrl #(
    parameter int DEPTH = 16,
    parameter int DW    = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_in_valid,
    input  logic [DW-1:0]         i_in_data,
    input  logic                  i_in_last,
    output logic                  o_in_ready,
    output logic                  o_arr_en,
    output logic [DW-1:0]         o_arr_new_data,
    output logic                  o_arr_clr,
    input  logic [DEPTH*DW-1:0]   i_arr_data_flat,
    output logic                  o_out_valid,
    output logic [DW-1:0]         o_out_data,
    output logic                  o_out_last,
    input  logic                  i_out_ready,
    output logic                  o_busy,
`ifdef SORT_CTRL_STATS_EN
    output logic [15:0]           o_drop_cnt,
`endif
    output logic [CW-1:0]         o_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_DRAIN  = 3'd3,
        S_CLEAR  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_rd_idx;
    logic [CW-1:0]   r_settle_cnt;
    logic            r_arr_en;
    logic [DW-1:0]   r_arr_new_data;
    logic            r_arr_clr;

    logic            w_key_nz;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_push;
    logic            w_drop;
    logic            w_out_valid;
    logic            w_out_last;
    logic            w_drain_hs;
    logic            w_busy;
    logic [DW-1:0]   w_rd_data;

    assign w_key_nz = |i_in_data[19:0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and combinational handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        w_drop      = 1'b0;
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
        w_drain_hs  = 1'b0;
        w_busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE, S_LOAD: begin
                w_in_ready = (r_count < CW'(DEPTH));
                w_accept   = i_in_valid && w_in_ready;
                w_push     = w_accept && w_key_nz;
                w_drop     = w_accept && !w_key_nz;
                if (w_push) begin
                    if (i_in_last || (r_count == CW'(DEPTH - 1))) begin
                        w_state_nxt = S_SETTLE;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end else if (w_drop && i_in_last) begin
                    // A dropped last record still closes the batch; an empty
                    // batch skips straight to the clear.
                    w_state_nxt = (r_count != '0) ? S_SETTLE : S_CLEAR;
                end
            end
            S_SETTLE: begin
                if (r_settle_cnt == '0) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_out_valid = 1'b1;
                w_out_last  = (r_rd_idx == (r_count - CW'(1)));
                w_drain_hs  = i_out_ready;
                if (w_drain_hs && w_out_last) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Select the cell addressed by the read index.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_rd_idx == CW'(i)) begin
                w_rd_data = i_arr_data_flat[i*DW +: DW];
            end
        end
    end

    // Datapath: array push bus, counters, settle timer and clear pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count        <= '0;
            r_rd_idx       <= '0;
            r_settle_cnt   <= '0;
            r_arr_en       <= 1'b0;
            r_arr_new_data <= '0;
            r_arr_clr      <= 1'b0;
        end else begin
            r_arr_clr <= (w_state_nxt == S_CLEAR);
            case (r_state)
                S_IDLE, S_LOAD: begin
                    r_arr_en     <= w_push;
                    r_settle_cnt <= CW'(DEPTH);
                    if (w_push) begin
                        r_arr_new_data <= i_in_data;
                        r_count        <= r_count + CW'(1);
                    end
                end
                S_SETTLE: begin
                    // Zero pushes ripple through every cell after the last record.
                    r_arr_en       <= (r_settle_cnt != '0);
                    r_arr_new_data <= '0;
                    if (r_settle_cnt != '0) begin
                        r_settle_cnt <= r_settle_cnt - CW'(1);
                    end
                end
                S_DRAIN: begin
                    r_arr_en <= 1'b0;
                    if (w_drain_hs && !w_out_last) begin
                        r_rd_idx <= r_rd_idx + CW'(1);
                    end
                end
                S_CLEAR: begin
                    r_arr_en <= 1'b0;
                    r_count  <= '0;
                    r_rd_idx <= '0;
                end
                default: begin
                    r_arr_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef SORT_CTRL_STATS_EN
    logic [15:0] r_drop_cnt;

    // Saturating count of dropped zero-key records; survives batch clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

    assign o_in_ready     = w_in_ready;
    assign o_arr_en       = r_arr_en;
    assign o_arr_new_data = r_arr_new_data;
    assign o_arr_clr      = r_arr_clr;
    assign o_out_valid    = w_out_valid;
    assign o_out_data     = w_out_valid ? w_rd_data : '0;
    assign o_out_last     = w_out_last;
    assign o_busy         = w_busy;
    assign o_count        = r_count;

endmodule
